// File: rtl/wb_bram_arbiter.sv
// Two-master Wishbone arbiter sharing one single-port BRAM slave; grant is registered, slave bus is muxed combinationally.
// Grant one edge after request, one IDLE cycle between grants; WB_ARB_ROUND_ROBIN_EN selects round-robin over fixed m0 priority.
module wb_bram_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_BURST    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic                    m0_ack_o,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic                    m1_ack_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic                    s_we_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic                    s_ack_i,
  output logic [1:0]              grant_o
);

  localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CNT_W-1:0] LP_SAT  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             w_burst_done;
  logic             w_pick_m1;

  // The ack that would complete the burst is the edge on which the grant is released.
  assign w_burst_done = (MAX_BURST != 0) && s_ack_i && (r_burst_cnt == LP_LAST);

`ifdef WB_ARB_ROUND_ROBIN_EN
  assign w_pick_m1 = ~r_last;
`else
  assign w_pick_m1 = r_last & 1'b0;
`endif

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_burst_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (w_next != IDLE) begin
          r_burst_cnt <= '0;
          r_last      <= (w_next == GNT1);
        end
      end else if (s_ack_i && (r_burst_cnt != LP_SAT)) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    grant_o  = 2'b00;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next = w_pick_m1 ? GNT1 : GNT0;
        end else if (m0_cyc_i) begin
          w_next = GNT0;
        end else if (m1_cyc_i) begin
          w_next = GNT1;
        end
      end
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_stb_o  = m0_stb_i;
        s_cyc_o  = m0_cyc_i;
        m0_ack_o = s_ack_i;
        grant_o  = 2'b01;
        if (!m0_cyc_i || (w_burst_done && m1_cyc_i)) begin
          w_next = IDLE;
        end
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_stb_o  = m1_stb_i;
        s_cyc_o  = m1_cyc_i;
        m1_ack_o = s_ack_i;
        grant_o  = 2'b10;
        if (!m1_cyc_i || (w_burst_done && m0_cyc_i)) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Bench for wb_bram_arbiter: BRAM slave model, queue-driven masters, per-cycle ownership model plus directed checks.
module tb_wb_bram_arbiter;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int SW = 4;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic          m0_we_i, m1_we_i, s_we_o;
  logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic          m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i, s_stb_o, s_cyc_o;
  logic          m0_ack_o, m1_ack_o, s_ack_i;
  logic [1:0]    grant_o;

  wb_bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  int n_checks = 0;
  int n_errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // BRAM slave: registered single-cycle ack, no new access on an ack edge; slow_ack delays ack one extra cycle.
  logic [DW-1:0] mem [0:511];
  logic          bram_ack = 1'b0;
  logic          ack_dly = 1'b0;
  logic          slow_ack = 1'b0;
  logic [DW-1:0] bram_rd = '0;
  logic          pre_en = 1'b0;
  logic [8:0]    pre_idx = '0;
  logic [DW-1:0] pre_val = '0;
  int            n_writes = 0;
  assign s_ack_i = bram_ack;
  assign s_dat_i = bram_rd;

  always @(posedge clk) begin
    bram_ack <= 1'b0;
    if (pre_en) mem[pre_idx] <= pre_val;
    if (ack_dly) begin
      bram_ack <= 1'b1;
      ack_dly  <= 1'b0;
    end else if (s_cyc_o && s_stb_o && !bram_ack) begin
      bram_rd <= mem[s_adr_o[AW-1:2]];
      if (s_we_o) begin
        for (int b = 0; b < SW; b++)
          if (s_sel_o[b]) mem[s_adr_o[AW-1:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
        n_writes++;
      end
      if (slow_ack) ack_dly <= 1'b1;
      else bram_ack <= 1'b1;
    end
  end

  // Ownership model: who owns the slave, how many acks it took, who was granted last.
  logic tb_run = 1'b0;
  int   own = -1;
  int   macks = 0;
  int   mlast = 1;
  logic [49:0] exp_bus;
  logic [1:0]  exp_gnt;
  logic        o_cyc, x_cyc;

  always @(negedge clk) begin
    if (tb_run) begin
      if (rst) begin
        own = -1; macks = 0; mlast = 1;
      end
      exp_bus = '0;
      exp_gnt = 2'b00;
      if (own == 0) begin
        exp_bus = {m0_adr_i, m0_dat_i, m0_we_i, m0_sel_i, m0_stb_i, m0_cyc_i};
        exp_gnt = 2'b01;
      end else if (own == 1) begin
        exp_bus = {m1_adr_i, m1_dat_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i};
        exp_gnt = 2'b10;
      end
      chk("mdl_slave_bus", {s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o}, exp_bus);
      chk("mdl_grant", grant_o, exp_gnt);
      chk("mdl_ack0", m0_ack_o, (own == 0) && s_ack_i);
      chk("mdl_ack1", m1_ack_o, (own == 1) && s_ack_i);
      chk("mdl_rdata", {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
      if (!rst) begin
        if (own < 0) begin
          if (m0_cyc_i && m1_cyc_i) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
            own = 1 - mlast;
`else
            own = 0;
`endif
          end else if (m0_cyc_i) own = 0;
          else if (m1_cyc_i) own = 1;
          if (own >= 0) begin
            macks = 0;
            mlast = own;
          end
        end else begin
          o_cyc = (own == 0) ? m0_cyc_i : m1_cyc_i;
          x_cyc = (own == 0) ? m1_cyc_i : m0_cyc_i;
          if (s_ack_i) macks++;
          if (!o_cyc || (MAXB != 0 && s_ack_i && macks == MAXB && x_cyc)) own = -1;
        end
      end
    end
  end

  // Queue-driven masters: hold each op until acked, then present the next or drop cyc.
  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } op_t;
  op_t q0[$];
  op_t q1[$];
  logic [DW-1:0] rd0[$];
  logic [DW-1:0] rd1[$];
  logic eng0 = 1'b1;
  logic eng1 = 1'b1;
  int ack0_cnt = 0;
  int ack1_cnt = 0;

  function automatic op_t mk(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                             input logic [SW-1:0] sel);
    op_t o;
    o.we = we; o.adr = adr; o.dat = dat; o.sel = sel;
    return o;
  endfunction

  task automatic drive_m0();
    if (q0.size() > 0) begin
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = q0[0].we;
      m0_adr_i = q0[0].adr; m0_dat_i = q0[0].dat; m0_sel_i = q0[0].sel;
    end else begin
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
      m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    end
  endtask

  task automatic drive_m1();
    if (q1.size() > 0) begin
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = q1[0].we;
      m1_adr_i = q1[0].adr; m1_dat_i = q1[0].dat; m1_sel_i = q1[0].sel;
    end else begin
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
      m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    end
  endtask

  task automatic push0(input op_t o);
    q0.push_back(o);
    if (eng0) drive_m0();
  endtask

  task automatic push1(input op_t o);
    q1.push_back(o);
    if (eng1) drive_m1();
  endtask

  task automatic tick();
    logic a0, a1;
    a0 = m0_ack_o;
    a1 = m1_ack_o;
    if (a0) ack0_cnt++;
    if (a1) ack1_cnt++;
    if (a0 && eng0 && q0.size() > 0 && !q0[0].we) rd0.push_back(m0_dat_o);
    if (a1 && eng1 && q1.size() > 0 && !q1[0].we) rd1.push_back(m1_dat_o);
    @(posedge clk);
    #1;
    if (eng0) begin
      if (a0 && q0.size() > 0) q0.delete(0);
      drive_m0();
    end
    if (eng1) begin
      if (a1 && q1.size() > 0) q1.delete(0);
      drive_m1();
    end
  endtask

  task automatic wait_all_idle(input string name);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || grant_o != 2'b00) && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_budget"}, n >= 300, 1'b0);
    tick();
    tick();
  endtask

  task automatic leave_and_next(input string name, output logic [1:0] g, output int idles);
    logic [1:0] cur;
    int n;
    cur = grant_o;
    n = 0;
    idles = 0;
    while (grant_o == cur && n < 300) begin tick(); n++; end
    while (grant_o == 2'b00 && n < 300) begin idles++; tick(); n++; end
    g = grant_o;
    chk({name, "_budget"}, n >= 300, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic [1:0] g, exp_second;
  int idles, a0s, a1s, w0, n;
  logic stale_seen, any_ack;

  initial begin
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_second = 2'b10;
`else
    exp_second = 2'b01;
`endif
    drive_m0();
    drive_m1();
    repeat (2) @(posedge clk);
    #1;
    pre_en = 1'b1; pre_idx = 9'(11'h010 >> 2); pre_val = 32'hDEADBEEF;
    tick();
    pre_en = 1'b0;
    tb_run = 1'b1;
    chk("reset_grant", grant_o, 2'b00);
    chk("reset_slave_cyc_stb_we", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
    chk("reset_acks", {m0_ack_o, m1_ack_o}, 2'b00);
    rst = 1'b0;
    tick();

    // Single read by m0.
    a1s = ack1_cnt;
    push0(mk(1'b0, 11'h010, '0, 4'hF));
    tick();
    chk("rd_grant_edge1", grant_o, 2'b01);
    chk("rd_slave_stb_adr", {s_stb_o, s_adr_o}, {1'b1, 11'h010});
    tick();
    chk("rd_ack_cycle2", m0_ack_o, 1'b1);
    chk("rd_data_cycle2", m0_dat_o, 32'hDEADBEEF);
    wait_all_idle("rd");
    chk("rd_m1_no_ack", ack1_cnt - a1s, 0);

    // Simultaneous requests, then a second contest after an m0 solo access.
    push0(mk(1'b0, 11'h010, '0, 4'hF));
    push1(mk(1'b0, 11'h010, '0, 4'hF));
    tick();
    chk("sim_first_winner", grant_o, 2'b01);
    leave_and_next("sim_handover", g, idles);
    chk("sim_handover_grant", g, 2'b10);
    chk("sim_handover_bubble", idles, 1);
    wait_all_idle("sim1");
    push0(mk(1'b0, 11'h010, '0, 4'hF));
    wait_all_idle("solo");
    push0(mk(1'b0, 11'h010, '0, 4'hF));
    push1(mk(1'b0, 11'h010, '0, 4'hF));
    tick();
    chk("sim_second_winner", grant_o, exp_second);
    wait_all_idle("sim2");

    // Byte-lane write by m1, readback by m0.
    push1(mk(1'b1, 11'h040, 32'hAAAAAAAA, 4'hF));
    push1(mk(1'b1, 11'h040, 32'h11223344, 4'b0100));
    wait_all_idle("bl_wr");
    rd0.delete();
    push0(mk(1'b0, 11'h040, '0, 4'hF));
    wait_all_idle("bl_rd");
    chk("bytelane_count", rd0.size(), 1);
    if (rd0.size() > 0) chk("bytelane_value", rd0[0], 32'hAA22AAAA);

    // Burst preemption: m0 ten writes while m1 waits.
    a0s = ack0_cnt; a1s = ack1_cnt; w0 = n_writes;
    rd1.delete();
    for (int i = 0; i < 10; i++) push0(mk(1'b1, 11'(11'h100 + 4 * i), 32'h1000 + i, 4'hF));
    tick();
    push1(mk(1'b0, 11'h040, '0, 4'hF));
    leave_and_next("pre", g, idles);
    chk("pre_first_burst_acks", ack0_cnt - a0s, MAXB);
    chk("pre_bubble", idles, 1);
    chk("pre_next_grant", g, exp_second);
    wait_all_idle("pre");
    chk("pre_m0_acks", ack0_cnt - a0s, 10);
    chk("pre_m1_acks", ack1_cnt - a1s, 1);
    chk("pre_bram_writes", n_writes - w0, 10);
    for (int i = 0; i < 10; i++) chk("pre_mem_word", mem[64 + i], 32'h1000 + i);
    if (rd1.size() > 0) chk("pre_m1_rdata", rd1[0], 32'hAA22AAAA);
    else chk("pre_m1_rdata_count", rd1.size(), 1);

    // Stale ack: m0 abandons its cycle after the slave latched the access.
    eng0 = 1'b0; slow_ack = 1'b1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 11'h010; m0_sel_i = 4'hF;
    tick();
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    stale_seen = 1'b0; any_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (s_ack_i && grant_o == 2'b00) stale_seen = 1'b1;
      if (m0_ack_o || m1_ack_o) any_ack = 1'b1;
      tick();
    end
    chk("stale_ack_arrived_idle", stale_seen, 1'b1);
    chk("stale_ack_not_routed", any_ack, 1'b0);
    slow_ack = 1'b0; eng0 = 1'b1;
    drive_m0();
    tick();

    // Asynchronous reset in the middle of a GNT1 cycle.
    for (int i = 0; i < 3; i++) push1(mk(1'b0, 11'h010, '0, 4'hF));
    n = 0;
    while (grant_o != 2'b10 && n < 50) begin tick(); n++; end
    chk("arst_reach_gnt1", grant_o, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant_now", grant_o, 2'b00);
    chk("arst_slave_cyc_now", {s_cyc_o, s_stb_o}, 2'b00);
    chk("arst_ack_now", m1_ack_o, 1'b0);
    q1.delete();
    drive_m1();
    tick();
    tick();
    rst = 1'b0;
    tick();
    push0(mk(1'b0, 11'h010, '0, 4'hF));
    push1(mk(1'b0, 11'h010, '0, 4'hF));
    tick();
    chk("arst_then_sim_winner", grant_o, 2'b01);
    wait_all_idle("arst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
